// File: rtl/morse_player_if.sv
// Character-in / keying-out bundle between the Morse codifier and morse_player.
// The abort signal exists only when MORSE_PLAYER_ABORT_EN is defined.
interface morse_player_if;
  // start is a single-cycle request with no ready: morse_player samples it only
  // in IDLE, busy stays high from acceptance until done, and done pulses once.
  logic       start;
  logic [4:0] morse;
  logic [4:0] display;
`ifdef MORSE_PLAYER_ABORT_EN
  logic       abort;
`endif
  logic       tone;
  logic       mark_dash;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

`ifdef MORSE_PLAYER_ABORT_EN
  modport master (output start, morse, display, abort,
                  input  tone, mark_dash, busy, done, dbg_state);
  modport slave  (input  start, morse, display, abort,
                  output tone, mark_dash, busy, done, dbg_state);
`else
  modport master (output start, morse, display,
                  input  tone, mark_dash, busy, done, dbg_state);
  modport slave  (input  start, morse, display,
                  output tone, mark_dash, busy, done, dbg_state);
`endif
endinterface

// File: rtl/morse_player.sv
// Plays one codified Morse character as timed on/off keying with standard unit timing.
// Optional MORSE_PLAYER_ABORT_EN adds an abort input that drops the character at once.
module morse_player #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_W       = 26
) (
  input  logic          clk,
  input  logic          reset,
  morse_player_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    LGAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt,   w_cnt;
  logic [4:0]       r_pat,   w_pat;
  logic [4:0]       r_mask,  w_mask;
  logic             r_tone,  w_tone;
  logic             r_dash,  w_dash;
  logic             r_busy,  w_busy;
  logic             r_done,  w_done;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pat   = r_pat;
    w_mask  = r_mask;
    w_tone  = r_tone;
    w_dash  = r_dash;
    w_busy  = r_busy;
    w_done  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start && bus.display[4]) begin
          w_pat   = bus.morse;
          w_mask  = bus.display;
          w_busy  = 1'b1;
          w_tone  = 1'b1;
          w_dash  = ~bus.morse[4];
          w_cnt   = bus.morse[4] ? DOT_LOAD : DASH_LOAD;
          w_state = MARK;
        end
      end
      MARK: begin
        if (w_cnt_zero) begin
          w_tone  = 1'b0;
          w_dash  = 1'b0;
          w_pat   = {r_pat[3:0], 1'b0};
          w_mask  = {r_mask[3:0], 1'b0};
          w_cnt   = DOT_LOAD;
          w_state = SPACE;
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end
      SPACE: begin
        // The mask was already shifted on leaving MARK, so bit 4 is the next symbol.
        if (w_cnt_zero) begin
          if (r_mask[4]) begin
            w_tone  = 1'b1;
            w_dash  = ~r_pat[4];
            w_cnt   = r_pat[4] ? DOT_LOAD : DASH_LOAD;
            w_state = MARK;
          end else begin
            w_cnt   = GAP_LOAD;
            w_state = LGAP;
          end
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end
      LGAP: begin
        if (w_cnt_zero) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end
      default: w_state = IDLE;
    endcase

`ifdef MORSE_PLAYER_ABORT_EN
    if (bus.abort && (r_state != IDLE)) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_pat   = '0;
      w_mask  = '0;
      w_tone  = 1'b0;
      w_dash  = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_mask  <= '0;
      r_tone  <= 1'b0;
      r_dash  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_pat   <= w_pat;
      r_mask  <= w_mask;
      r_tone  <= w_tone;
      r_dash  <= w_dash;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.tone      = r_tone;
  assign bus.mark_dash = r_dash;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player with UNIT_CYCLES = 4: waveform per clock against
// an expected queue built from the Morse timing rules, plus hand-computed busy lengths.
module tb_morse_player;
  localparam int U = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_q[$];

  morse_player_if bus();

  morse_player #(.UNIT_CYCLES(U), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {bus.tone, bus.mark_dash, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Expected {tone, mark_dash, busy, done} per sampled clock after the accepting edge.
  function automatic void build(input logic [4:0] m, input logic [4:0] d);
    int n = 0;
    exp_q.delete();
    for (int i = 4; i >= 0; i--) begin
      if (!d[i]) break;
      n++;
    end
    for (int k = 0; k < n; k++) begin
      int len = m[4-k] ? U : 3 * U;
      int gap = (k == n - 1) ? 3 * U : U;
      repeat (len) exp_q.push_back({1'b1, ~m[4-k], 1'b1, 1'b0});
      repeat (gap) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endfunction

  task automatic run_char(input logic [4:0] m, input logic [4:0] d, input int repulse_at,
                          input int exp_busy, input string tag);
    int busy_cnt = 0;
    build(m, d);
    bus.morse   = m;
    bus.display = d;
    bus.start   = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      bus.start   = (k == repulse_at);
      bus.morse   = 5'($urandom_range(0, 31));
      bus.display = (k == repulse_at) ? 5'b11111 : 5'($urandom_range(0, 31));
      if (bus.busy) busy_cnt++;
      check(tag, 8'(obs()), 8'(exp_q[k]));
    end
    bus.start = 1'b0;
    check({tag, "_busy_len"}, 8'(busy_cnt), 8'(exp_busy));
  endtask

  task automatic idle_check(input string tag);
    tick();
    check(tag, 8'(obs()), 8'b0000);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.morse   = 5'b0;
    bus.display = 5'b0;
`ifdef MORSE_PLAYER_ABORT_EN
    bus.abort   = 1'b0;
`endif
    tick();
    tick();
    check("reset_out", 8'(obs()), 8'b0000);
    check("reset_state", 8'(bus.dbg_state), 8'd0);
    reset = 1'b1;
    idle_check("post_reset_idle");

    // display[4] = 0 must never be accepted.
    bus.start   = 1'b1;
    bus.morse   = 5'b11111;
    bus.display = 5'b00000;
    repeat (3) idle_check("reject_empty");
    bus.start = 1'b0;

    run_char(5'b10110, 5'b10000, -1, 16, "letter_E");
    idle_check("idle_after_E");
    run_char(5'b10101, 5'b11000, -1, 32, "letter_A");
    idle_check("idle_after_A");
    run_char(5'b00000, 5'b11111, -1, 88, "digit_0");
    idle_check("idle_after_0");
    run_char(5'b10000, 5'b10101, -1, 16, "mask_gap_E");
    idle_check("idle_after_mask");
    run_char(5'b10000, 5'b11000, 10, 32, "repulse_A");
    idle_check("idle_after_repulse");

    // Start presented during the done cycle is taken on the next edge.
    run_char(5'b10000, 5'b10000, -1, 16, "b2b_E");
    run_char(5'b10000, 5'b11000, -1, 32, "b2b_A");
    idle_check("idle_after_b2b");

    // Reset in the middle of a 12-clock dash (letter T).
    bus.morse   = 5'b01111;
    bus.display = 5'b10000;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check("T_first", 8'(obs()), 8'b1110);
    repeat (5) tick();
    check("T_mid", 8'(obs()), 8'b1110);
    reset = 1'b0;
    tick();
    check("mid_reset_out", 8'(obs()), 8'b0000);
    check("mid_reset_state", 8'(bus.dbg_state), 8'd0);
    reset = 1'b1;
    repeat (20) idle_check("no_done_after_reset");
    run_char(5'b10000, 5'b10000, -1, 16, "E_after_reset");
    idle_check("idle_after_reset_E");

`ifdef MORSE_PLAYER_ABORT_EN
    // Abort during the space of letter A.
    build(5'b10000, 5'b11000);
    bus.morse   = 5'b10000;
    bus.display = 5'b11000;
    bus.start   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.start = 1'b0;
      check("abort_A_pre", 8'(obs()), 8'(exp_q[k]));
    end
    check("abort_A_in_space", 8'(bus.dbg_state), 8'd2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_out", 8'(obs()), 8'b0000);
    repeat (15) idle_check("abort_no_done");

    bus.abort = 1'b1;
    idle_check("abort_in_idle");

    // abort and start together in IDLE: start wins.
    build(5'b10000, 5'b10000);
    bus.start   = 1'b1;
    bus.display = 5'b10000;
    bus.morse   = 5'b10000;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("abort_start_E", 8'(obs()), 8'(exp_q[k]));
    end
    idle_check("idle_after_abort_start");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
